// File: rtl/sd_cmd_frame_decoder.sv
// SD-SPI command frame decoder: assembles 6-byte command frames from the SPI
// receive buffer, checks end bit and CRC7, and hands them off with valid/ack.
module sd_cmd_frame_decoder #(
  parameter logic CHECK_CRC = 1'b1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        CS,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  input  logic        Ack,
  output logic [5:0]  CmdIndex,
  output logic [31:0] Argument,
  output logic [6:0]  Crc,
  output logic        FrameValid,
  output logic        FrameError,
  output logic        Overrun,
  output logic        Busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARG,
    ST_CRC,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        vprev_q;
  logic [1:0]  cnt_q, cnt_d;
  logic [6:0]  crc_acc_q, crc_acc_d;
  logic [5:0]  cmd_q, cmd_d;
  logic [31:0] arg_q, arg_d;
  logic [6:0]  crc_q, crc_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        overrun_q, overrun_d;

  logic        stb;
  logic        act;
  logic        is_start;
  logic [6:0]  crc_seed;
  logic [6:0]  crc_step;

  // CRC7, polynomial x^7 + x^3 + 1, one byte MSB first.
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in,
                                           input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) begin
        c = c ^ 7'h09;
      end
    end
    return c;
  endfunction

  assign stb      = ByteValid & ~vprev_q;
  assign act      = stb & ~CS;
  assign is_start = (ByteIn[7:6] == 2'b01);
  assign crc_seed = crc7_byte(7'd0, ByteIn);
  assign crc_step = crc7_byte(crc_acc_q, ByteIn);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    crc_acc_d = crc_acc_q;
    cmd_d     = cmd_q;
    arg_d     = arg_q;
    crc_d     = crc_q;
    valid_d   = valid_q;
    err_d     = err_q;
    overrun_d = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (act && is_start) begin
          cmd_d     = ByteIn[5:0];
          crc_acc_d = crc_seed;
          cnt_d     = 2'd0;
          state_d   = ST_ARG;
        end
      end
      ST_ARG: begin
        if (CS) begin
          state_d = ST_IDLE;
        end else if (act) begin
          arg_d     = {arg_q[23:0], ByteIn};
          crc_acc_d = crc_step;
          cnt_d     = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_CRC;
          end
        end
      end
      ST_CRC: begin
        if (CS) begin
          state_d = ST_IDLE;
        end else if (act) begin
          crc_d   = ByteIn[7:1];
          err_d   = ~ByteIn[0] | (CHECK_CRC & (ByteIn[7:1] != crc_acc_q));
          valid_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // A start byte in the release cycle begins the next frame directly.
        if (Ack) begin
          valid_d = 1'b0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
          if (act && is_start) begin
            cmd_d     = ByteIn[5:0];
            crc_acc_d = crc_seed;
            cnt_d     = 2'd0;
            state_d   = ST_ARG;
          end
        end else if (act && is_start) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      vprev_q   <= 1'b0;
      cnt_q     <= 2'd0;
      crc_acc_q <= 7'd0;
      cmd_q     <= 6'd0;
      arg_q     <= 32'd0;
      crc_q     <= 7'd0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vprev_q   <= ByteValid;
      cnt_q     <= cnt_d;
      crc_acc_q <= crc_acc_d;
      cmd_q     <= cmd_d;
      arg_q     <= arg_d;
      crc_q     <= crc_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
    end
  end

  assign CmdIndex   = cmd_q;
  assign Argument   = arg_q;
  assign Crc        = crc_q;
  assign FrameValid = valid_q;
  assign FrameError = err_q;
  assign Overrun    = overrun_q;
  assign Busy       = (state_q == ST_ARG) || (state_q == ST_CRC);

endmodule

// File: tb/tb_sd_cmd_frame_decoder.sv
// Directed bench for sd_cmd_frame_decoder: table of known SD command frames
// plus hand-written sequences for abort, overrun/handshake and async reset.
module tb_sd_cmd_frame_decoder;

  logic        CLK;
  logic        reset;
  logic        CS;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        Ack;
  logic [5:0]  CmdIndex, CmdIndexNc;
  logic [31:0] Argument, ArgumentNc;
  logic [6:0]  Crc, CrcNc;
  logic        FrameValid, FrameValidNc;
  logic        FrameError, FrameErrorNc;
  logic        Overrun, OverrunNc;
  logic        Busy, BusyNc;

  int checks;
  int failures;

  sd_cmd_frame_decoder #(.CHECK_CRC(1'b1)) dut (
    .CLK(CLK), .reset(reset), .CS(CS), .ByteIn(ByteIn), .ByteValid(ByteValid),
    .Ack(Ack), .CmdIndex(CmdIndex), .Argument(Argument), .Crc(Crc),
    .FrameValid(FrameValid), .FrameError(FrameError), .Overrun(Overrun), .Busy(Busy)
  );

  sd_cmd_frame_decoder #(.CHECK_CRC(1'b0)) dutNc (
    .CLK(CLK), .reset(reset), .CS(CS), .ByteIn(ByteIn), .ByteValid(ByteValid),
    .Ack(Ack), .CmdIndex(CmdIndexNc), .Argument(ArgumentNc), .Crc(CrcNc),
    .FrameValid(FrameValidNc), .FrameError(FrameErrorNc), .Overrun(OverrunNc), .Busy(BusyNc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [47:0] frame;
    int          nFill;
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic        errChk;
    logic        errNoChk;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One byte per call: ByteValid high across one posedge, low across the next.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge CLK);
    ByteIn    = b;
    ByteValid = 1'b1;
    @(negedge CLK);
    ByteValid = 1'b0;
  endtask

  task automatic sendFrame(input logic [47:0] f);
    logic [7:0] b;
    for (int k = 0; k < 6; k++) begin
      b = f[47 - 8*k -: 8];
      applyStimulus(b);
    end
  endtask

  task automatic pulseAck();
    @(negedge CLK);
    Ack = 1'b1;
    @(negedge CLK);
    Ack = 1'b0;
  endtask

  initial begin
    logic [47:0] f;
    logic [7:0]  b;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    CS        = 1'b0;
    ByteIn    = 8'hFF;
    ByteValid = 1'b0;
    Ack       = 1'b0;

    vecs[0] = '{48'h40_00000000_95, 0, 6'd0,  32'h00000000, 7'h4A, 1'b0, 1'b0};
    vecs[1] = '{48'h48_000001AA_87, 3, 6'd8,  32'h000001AA, 7'h43, 1'b0, 1'b0};
    vecs[2] = '{48'h48_000001AA_89, 0, 6'd8,  32'h000001AA, 7'h44, 1'b1, 1'b0};
    vecs[3] = '{48'h48_000001AA_86, 0, 6'd8,  32'h000001AA, 7'h43, 1'b1, 1'b1};
    vecs[4] = '{48'h77_00000000_65, 0, 6'd55, 32'h00000000, 7'h32, 1'b0, 1'b0};
    vecs[5] = '{48'h69_40000000_77, 0, 6'd41, 32'h40000000, 7'h3B, 1'b0, 1'b0};

    #12;
    checkOutput("rst_valid",   {31'd0, FrameValid}, 32'd0);
    checkOutput("rst_error",   {31'd0, FrameError}, 32'd0);
    checkOutput("rst_overrun", {31'd0, Overrun},    32'd0);
    checkOutput("rst_busy",    {31'd0, Busy},       32'd0);
    checkOutput("rst_cmd",     {26'd0, CmdIndex},   32'd0);
    checkOutput("rst_arg",     Argument,            32'd0);
    checkOutput("rst_crc",     {25'd0, Crc},        32'd0);
    @(negedge CLK);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < vecs[i].nFill; j++) begin
        applyStimulus(8'hFF);
        checkOutput($sformatf("v%0d_fill_busy", i), {31'd0, Busy}, 32'd0);
      end
      f = vecs[i].frame;
      for (int k = 0; k < 6; k++) begin
        b = f[47 - 8*k -: 8];
        applyStimulus(b);
        if (k == 0)
          checkOutput($sformatf("v%0d_busy_start", i), {31'd0, Busy}, 32'd1);
        if (k == 4)
          checkOutput($sformatf("v%0d_valid_early", i), {31'd0, FrameValid}, 32'd0);
      end
      checkOutput($sformatf("v%0d_valid", i),   {31'd0, FrameValid},   32'd1);
      checkOutput($sformatf("v%0d_err", i),     {31'd0, FrameError},   {31'd0, vecs[i].errChk});
      checkOutput($sformatf("v%0d_err_nc", i),  {31'd0, FrameErrorNc}, {31'd0, vecs[i].errNoChk});
      checkOutput($sformatf("v%0d_cmd", i),     {26'd0, CmdIndex},     {26'd0, vecs[i].cmd});
      checkOutput($sformatf("v%0d_arg", i),     Argument,              vecs[i].arg);
      checkOutput($sformatf("v%0d_crc", i),     {25'd0, Crc},          {25'd0, vecs[i].crc});
      checkOutput($sformatf("v%0d_busy_done", i), {31'd0, Busy},       32'd0);
      pulseAck();
      checkOutput($sformatf("v%0d_ack_valid", i), {31'd0, FrameValid}, 32'd0);
      checkOutput($sformatf("v%0d_ack_err", i),   {31'd0, FrameError}, 32'd0);
      checkOutput($sformatf("v%0d_overrun", i),   {31'd0, Overrun},    32'd0);
    end

    // CS abort after three argument bytes, then a clean CMD0.
    applyStimulus(8'h48);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    checkOutput("abort_busy_before", {31'd0, Busy}, 32'd1);
    @(negedge CLK);
    CS = 1'b1;
    @(negedge CLK);
    checkOutput("abort_busy_gap", {31'd0, Busy}, 32'd0);
    applyStimulus(8'h40);
    checkOutput("abort_cs_stb_ignored", {31'd0, Busy}, 32'd0);
    CS = 1'b0;
    sendFrame(48'h40_00000000_95);
    checkOutput("abort_valid", {31'd0, FrameValid}, 32'd1);
    checkOutput("abort_cmd",   {26'd0, CmdIndex},   32'd0);
    checkOutput("abort_arg",   Argument,            32'd0);
    checkOutput("abort_crc",   {25'd0, Crc},        32'h4A);
    checkOutput("abort_err",   {31'd0, FrameError}, 32'd0);

    // Second frame while the first is held: dropped, Overrun set.
    sendFrame(48'h48_000001AA_87);
    checkOutput("ovr_flag",  {31'd0, Overrun},    32'd1);
    checkOutput("ovr_valid", {31'd0, FrameValid}, 32'd1);
    checkOutput("ovr_cmd",   {26'd0, CmdIndex},   32'd0);
    checkOutput("ovr_arg",   Argument,            32'd0);
    checkOutput("ovr_crc",   {25'd0, Crc},        32'h4A);
    @(negedge CLK);
    CS = 1'b1;
    @(negedge CLK);
    CS = 1'b0;
    checkOutput("done_cs_hold", {31'd0, FrameValid}, 32'd1);

    // Ack coinciding with a start byte: release and restart in one edge.
    @(negedge CLK);
    Ack       = 1'b1;
    ByteIn    = 8'h48;
    ByteValid = 1'b1;
    @(negedge CLK);
    Ack       = 1'b0;
    ByteValid = 1'b0;
    checkOutput("ackstart_valid",   {31'd0, FrameValid}, 32'd0);
    checkOutput("ackstart_busy",    {31'd0, Busy},       32'd1);
    checkOutput("ackstart_overrun", {31'd0, Overrun},    32'd1);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'hAA);
    applyStimulus(8'h87);
    checkOutput("ackstart_fvalid", {31'd0, FrameValid}, 32'd1);
    checkOutput("ackstart_cmd",    {26'd0, CmdIndex},   32'd8);
    checkOutput("ackstart_arg",    Argument,            32'h000001AA);
    checkOutput("ackstart_crc",    {25'd0, Crc},        32'h43);
    checkOutput("ackstart_err",    {31'd0, FrameError}, 32'd0);
    pulseAck();

    // Asynchronous reset in the middle of the argument bytes.
    applyStimulus(8'h40);
    applyStimulus(8'h00);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("areset_busy",    {31'd0, Busy},       32'd0);
    checkOutput("areset_overrun", {31'd0, Overrun},    32'd0);
    checkOutput("areset_valid",   {31'd0, FrameValid}, 32'd0);
    checkOutput("areset_cmd",     {26'd0, CmdIndex},   32'd0);
    checkOutput("areset_arg",     Argument,            32'd0);
    @(negedge CLK);
    reset = 1'b0;
    sendFrame(48'h40_00000000_95);
    checkOutput("post_valid", {31'd0, FrameValid}, 32'd1);
    checkOutput("post_err",   {31'd0, FrameError}, 32'd0);
    checkOutput("post_cmd",   {26'd0, CmdIndex},   32'd0);
    checkOutput("post_crc",   {25'd0, Crc},        32'h4A);
    pulseAck();
    checkOutput("post_ack", {31'd0, FrameValid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
